// File: rtl/fetch_queue.sv
// fetch_queue: four-entry decoupling FIFO between instruction fetch and decode.
// Each entry carries an instruction word plus its branch-prediction metadata.
// Occupancy lives in a dedicated count register so that full and empty stay
// distinct even when the two pointers are equal. A flush from commit empties
// the queue in one cycle and leaves the stored data untouched.
module fetch_queue #(
  parameter int WIDTH = 31,  // MSB index of data/address words
  parameter int INDEX = 7,   // MSB index of the gshare GHR index
  parameter int PTR   = 1    // MSB index of the pointers; depth = 2^(PTR+1)
) (
  input  logic             clk,
  input  logic             globalReset,
  input  logic             flush,
  input  logic             pushValid,
  output logic             pushReady,
  input  logic [WIDTH:0]   instrIn,
  input  logic [WIDTH:0]   pcIn,
  input  logic [WIDTH:0]   predPCIn,
  input  logic             redirectIn,
  input  logic [INDEX:0]   ghrIn,
  input  logic [1:0]       phtIn,
  output logic             popValid,
  input  logic             popReady,
  output logic [WIDTH:0]   instrOut,
  output logic [WIDTH:0]   pcOut,
  output logic [WIDTH:0]   predPCOut,
  output logic             redirectOut,
  output logic [INDEX:0]   ghrOut,
  output logic [1:0]       phtOut,
  output logic [PTR+1:0]   count
);

  localparam int DEPTH = 1 << (PTR + 1);
  localparam logic [PTR+1:0] FULL_COUNT = (PTR + 2)'(DEPTH);
  localparam logic [PTR+1:0] CNT_ONE    = (PTR + 2)'(1);
  localparam logic [PTR:0]   PTR_ONE    = (PTR + 1)'(1);

  typedef struct packed {
    logic [WIDTH:0] instr;
    logic [WIDTH:0] pc;
    logic [WIDTH:0] pred_pc;
    logic           redirect;
    logic [INDEX:0] ghr;
    logic [1:0]     pht;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PTR:0]    wp;
  logic [PTR:0]    rp;
  logic [PTR+1:0]  count_q;

  logic   full;
  logic   empty;
  logic   push;
  logic   pop;
  entry_t push_entry;
  entry_t head;

  // Flags come from registered state only, so pushReady never depends on popReady.
  assign full      = (count_q == FULL_COUNT);
  assign empty     = (count_q == '0);
  assign pushReady = !full;
  assign popValid  = !empty;
  assign count     = count_q;

  // Handshakes that actually move data this cycle.
  assign push = pushValid && !full;
  assign pop  = popReady && !empty;

  assign push_entry = '{
    instr:    instrIn,
    pc:       pcIn,
    pred_pc:  predPCIn,
    redirect: redirectIn,
    ghr:      ghrIn,
    pht:      phtIn
  };

  // Head fields are read combinationally from the entry at the read pointer.
  assign head        = mem[rp];
  assign instrOut    = head.instr;
  assign pcOut       = head.pc;
  assign predPCOut   = head.pred_pc;
  assign redirectOut = head.redirect;
  assign ghrOut      = head.ghr;
  assign phtOut      = head.pht;

  // Entry storage: written on an accepted push, cleared only by reset.
  always_ff @(posedge clk or negedge globalReset) begin
    if (!globalReset) begin
      // NOTE: the array is reset so the head outputs read 0 after reset; this
      // forces flops instead of a RAM macro, which is fine for four entries.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push && !flush) begin
      mem[wp] <= push_entry;
    end
  end

  // Pointers and occupancy; flush wins over any push or pop in the same cycle.
  always_ff @(posedge clk or negedge globalReset) begin
    if (!globalReset) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the values from before the edge, independent of block order.
      wp      <= '0;
      rp      <= '0;
      count_q <= '0;
    end else if (flush) begin
      wp      <= '0;
      rp      <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wp <= wp + PTR_ONE;
      end
      if (pop) begin
        rp <= rp + PTR_ONE;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios plus randomized traffic, checked each
// cycle against a queue-based reference model of the fetch queue.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        globalReset;
  logic        flush;
  logic        pushValid;
  logic        pushReady;
  logic [31:0] instrIn;
  logic [31:0] pcIn;
  logic [31:0] predPCIn;
  logic        redirectIn;
  logic [7:0]  ghrIn;
  logic [1:0]  phtIn;
  logic        popValid;
  logic        popReady;
  logic [31:0] instrOut;
  logic [31:0] pcOut;
  logic [31:0] predPCOut;
  logic        redirectOut;
  logic [7:0]  ghrOut;
  logic [1:0]  phtOut;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pred;
    logic        redir;
    logic [7:0]  ghr;
    logic [1:0]  pht;
  } ent_t;

  ent_t mq[$];

  fetch_queue dut (
    .clk         (clk),
    .globalReset (globalReset),
    .flush       (flush),
    .pushValid   (pushValid),
    .pushReady   (pushReady),
    .instrIn     (instrIn),
    .pcIn        (pcIn),
    .predPCIn    (predPCIn),
    .redirectIn  (redirectIn),
    .ghrIn       (ghrIn),
    .phtIn       (phtIn),
    .popValid    (popValid),
    .popReady    (popReady),
    .instrOut    (instrOut),
    .pcOut       (pcOut),
    .predPCOut   (predPCOut),
    .redirectOut (redirectOut),
    .ghrOut      (ghrOut),
    .phtOut      (phtOut),
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic pv, input logic pr, input logic fl,
                       input logic [31:0] instr, input logic [31:0] pc);
    pushValid  = pv;
    popReady   = pr;
    flush      = fl;
    instrIn    = instr;
    pcIn       = pc;
    predPCIn   = pc + 32'd4;
    redirectIn = 1'b0;
    ghrIn      = 8'($urandom);
    phtIn      = 2'($urandom);
  endtask

  // Compare every visible output against the model; head fields only when valid.
  task automatic compare_all();
    check("count", 32'(count), 32'(mq.size()));
    check("popValid", 32'(popValid), 32'(mq.size() != 0));
    check("pushReady", 32'(pushReady), 32'(mq.size() < 4));
    if (mq.size() != 0) begin
      check("instrOut", instrOut, mq[0].instr);
      check("pcOut", pcOut, mq[0].pc);
      check("predPCOut", predPCOut, mq[0].pred);
      check("redirectOut", 32'(redirectOut), 32'(mq[0].redir));
      check("ghrOut", 32'(ghrOut), 32'(mq[0].ghr));
      check("phtOut", 32'(phtOut), 32'(mq[0].pht));
    end
  endtask

  // One clock: apply the FIFO rules to the model at the edge, check at negedge.
  task automatic step();
    bit   do_push;
    bit   do_pop;
    ent_t e;
    @(posedge clk);
    e = '{instr: instrIn, pc: pcIn, pred: predPCIn, redir: redirectIn,
          ghr: ghrIn, pht: phtIn};
    do_push = pushValid && (mq.size() < 4);
    do_pop  = popReady && (mq.size() > 0);
    if (flush) begin
      mq.delete();
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
    @(negedge clk);
    compare_all();
  endtask

  logic [31:0] fill_instr [4];

  initial begin
    fill_instr[0] = 32'h00000013;
    fill_instr[1] = 32'h00100093;
    fill_instr[2] = 32'h00200113;
    fill_instr[3] = 32'h00300193;

    globalReset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset then idle.
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_popValid", 32'(popValid), 32'd0);
    check("rst_pushReady", 32'(pushReady), 32'd1);
    repeat (2) @(negedge clk);
    globalReset = 1'b1;
    step();
    check("idle_instrOut", instrOut, 32'd0);

    // Fill with decode stalled, then try a fifth push.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, fill_instr[i], 32'(i * 4));
      step();
    end
    check("fill_count", 32'(count), 32'd4);
    check("fill_pushReady", 32'(pushReady), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 32'h10);
    step();
    check("overfill_count", 32'(count), 32'd4);

    // Drain in order.
    for (int i = 0; i < 4; i++) begin
      check("drain_instr", instrOut, fill_instr[i]);
      drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      step();
    end
    check("drained_popValid", 32'(popValid), 32'd0);

    // Simultaneous push and pop at count 2 across pointer wrap.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'($urandom), 32'h200 + 32'(i * 4));
      step();
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'($urandom), 32'h208 + 32'(i * 4));
      step();
      check("pp_count", 32'(count), 32'd2);
    end

    // Full plus pop: pop accepted, push rejected.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'($urandom), 32'h300 + 32'(i * 4));
      step();
    end
    check("full_count", 32'(count), 32'd4);
    drive(1'b1, 1'b1, 1'b0, 32'h0BADF00D, 32'h400);
    step();
    check("fullpop_count", 32'(count), 32'd3);
    check("fullpop_pushReady", 32'(pushReady), 32'd1);

    // Flush priority at count 3.
    drive(1'b1, 1'b1, 1'b1, 32'h11111111, 32'h500);
    step();
    check("flush_count", 32'(count), 32'd0);
    check("flush_popValid", 32'(popValid), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h22222222, 32'h100);
    redirectIn = 1'b1;
    ghrIn      = 8'hA5;
    phtIn      = 2'd2;
    step();
    check("postflush_pc", pcOut, 32'h100);
    check("postflush_redirect", 32'(redirectOut), 32'd1);
    check("postflush_ghr", 32'(ghrOut), 32'hA5);
    check("postflush_pht", 32'(phtOut), 32'd2);

    // Multi-cycle flush keeps the queue empty.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, 32'($urandom), 32'h600);
      step();
    end

    // Async reset mid-burst at count 2.
    drive(1'b1, 1'b0, 1'b0, 32'hAAAA0001, 32'h700);
    step();
    drive(1'b1, 1'b0, 1'b0, 32'hAAAA0002, 32'h704);
    step();
    check("prereset_count", 32'(count), 32'd2);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #2 globalReset = 1'b0;
    #1;
    check("async_count", 32'(count), 32'd0);
    check("async_popValid", 32'(popValid), 32'd0);
    check("async_pushReady", 32'(pushReady), 32'd1);
    check("async_instrOut", instrOut, 32'd0);
    mq.delete();
    @(negedge clk);
    globalReset = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 99) < 3), 32'($urandom), 32'($urandom));
      predPCIn   = 32'($urandom);
      redirectIn = 1'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling FIFO between the instruction fetch unit and the instruction decode stage.
- Buffers each fetched instruction together with its branch-prediction metadata (PC, predicted next PC, redirect flag, GHR index, PHT state).
- Absorbs decode stalls (ROB/RS full) so fetch can run ahead.
- Flushed in a single cycle on a control-flow misprediction signalled at commit.

Parameters:
- WIDTH, 31, MSB index of data/address words (32-bit).
- INDEX, 7, MSB index of gshare GHR index (8-bit).
- PTR, 1, MSB index of read/write pointers; queue depth = 2^(PTR+1) = 4 entries.

Ports:
- clk  input  1  system clock, all state on rising edge.
- globalReset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous flush (misprediction/redirect from commit); empties queue.
- pushValid  input  1  fetch presents a valid entry.
- pushReady  output  1  queue can accept an entry this cycle.
- instrIn  input  WIDTH+1  fetched instruction word.
- pcIn  input  WIDTH+1  instruction PC.
- predPCIn  input  WIDTH+1  predicted next PC.
- redirectIn  input  1  predictor redirected flow.
- ghrIn  input  INDEX+1  GHR index used for prediction.
- phtIn  input  2  PHT counter state read.
- popValid  output  1  head entry valid for decode.
- popReady  input  1  decode consumes head this cycle.
- instrOut, pcOut, predPCOut  output  WIDTH+1 each  head entry fields.
- redirectOut  output  1  head entry field.
- ghrOut  output  INDEX+1  head entry field.
- phtOut  output  2  head entry field.
- count  output  PTR+2  number of occupied entries (0..4).

Behaviour:
- Clock and reset: single clock clk. globalReset is asynchronous, active-low. While low, all of the following are forced immediately, independent of clk:
  - pointers = 0, count = 0, popValid = 0, pushReady = 1;
  - all storage cleared, so all head data outputs read 0.
- Storage: circular array of 4 entries with write pointer wp and read pointer rp (PTR+1 bits each, wrap modulo 4), plus a count register.
- Flags:
  - full = (count == 4); empty = (count == 0).
  - pushReady = !full. It is registered-state derived only and has no combinational dependence on popReady.
  - popValid = !empty.
  - Head outputs are driven combinationally from entry[rp]; their value is don't-care when popValid = 0.
- Push: when pushValid && pushReady, on the clock edge the entry is written at wp and wp increments.
- Pop: when popValid && popReady, on the clock edge rp increments.
- Count update:
  - +1 on push-only, -1 on pop-only, unchanged on simultaneous push and pop.
  - Push while full is blocked by pushReady = 0, even if a pop occurs in the same cycle.
  - popReady while empty is ignored.
- Latency: an entry pushed in cycle N appears at the head (popValid = 1) in cycle N+1 if the queue was empty, i.e. one-cycle fall-through; there is no same-cycle bypass.
- Ordering: strict FIFO. Entries leave in push order; no reordering or dropping except on flush.
- Flush (flush = 1 at the edge):
  - wp, rp and count are reset to 0;
  - any push or pop in that same cycle is discarded, so flush has priority;
  - storage contents are not cleared;
  - the next cycle shows popValid = 0 and pushReady = 1.
- Flush combined with other events:
  - Flush asserted for multiple cycles keeps the queue empty.
  - A push in the cycle after flush deasserts is accepted normally.
- Wrap-around: pointers wrap 3 -> 0 with no bubble; full and empty are distinguished by count, not by pointer compare.
- Reset mid-operation: asynchronous assertion discards all contents immediately. Deassertion is synchronised externally; the first edge after deassertion behaves as normal operation on an empty queue.

Test Plan:
- Reset then idle:
  - Hold globalReset = 0 for 2 cycles, then release -> popValid = 0, pushReady = 1, count = 0, instrOut = 0.
- Fill and drain:
  - With popReady = 0, push instr 0x00000013/pc 0x0, 0x00100093/pc 0x4, 0x00200113/pc 0x8, 0x00300193/pc 0xC -> count = 4, pushReady = 0.
  - A 5th push of 0xDEADBEEF is not stored.
  - Then popReady = 1 -> outputs 0x13, 0x00100093, 0x00200113, 0x00300193 in order, then popValid = 0.
- Simultaneous push and pop:
  - Hold count = 2 with pushValid = popReady = 1 for 6 cycles -> count stays 2.
  - Pointers wrap; popped PC sequence matches push order.
- Full plus pop:
  - At count = 4, pushValid = 1 and popReady = 1 -> head popped, push rejected, count = 3; next cycle pushReady = 1.
- Flush priority:
  - At count = 3, assert flush together with pushValid and popReady for one cycle -> next cycle count = 0, popValid = 0.
  - Next push of pc 0x100 (redirectIn = 1, ghrIn = 0xA5, phtIn = 2) appears at head after one cycle with those exact fields.
- Async reset mid-burst:
  - Drop globalReset between clock edges while count = 2 -> count = 0 and popValid = 0 before the next edge.
